cnt_updown_n: RTL and testbench
===============================

CNT_UPDOWN_N -- requirements
Module: cnt_updown_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (2..32).
REQ-002 SHALL have parameter MIN, default 0, lower count bound; MIN < MAX.
REQ-003 SHALL have parameter MAX, default 2**WIDTH-1, upper count bound; MAX <= 2**WIDTH-1.
REQ-004 SHALL have parameter STEP_W, default 2, width of the step input.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock, the only clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port en  input  1  count enable.
REQ-008 SHALL have port u_d  input  1  requested direction; 0 = up, 1 = down.
REQ-009 SHALL have port mode  input  1  boundary mode; 0 = wrap, 1 = saturate.
REQ-010 SHALL have port step  input  STEP_W  increment magnitude; 0 is treated as 1.
REQ-011 SHALL have port load  input  1  synchronous load strobe.
REQ-012 SHALL have port load_val  input  WIDTH  value to load.
REQ-013 SHALL have port cnt  output  WIDTH  registered count.
REQ-014 SHALL have port dir  output  1  registered direction currently in use.
REQ-015 SHALL have port tc  output  1  registered one-cycle pulse on a wrap or saturation event.

Function
REQ-016 SHALL sample u_d into dir on every rising clk edge; the count update at edge N SHALL use dir as registered at edge N-1, giving one cycle of direction latency.
REQ-017 SHALL have priority load > en > hold.
REQ-018 SHALL, when load=1, set cnt to load_val clamped into [MIN,MAX], leave tc=0, and ignore en.
REQ-019 SHALL, when en=0 and load=0, hold cnt and drive tc=0.
REQ-020 SHALL, when en=1, compute the next value with effective step s = max(step,1), in WIDTH+STEP_W+1-bit arithmetic with no intermediate overflow.
REQ-021 SHALL in wrap mode (up), for cnt+s > MAX, set cnt = MIN + (cnt+s-MAX-1) mod (MAX-MIN+1) and pulse tc.
REQ-022 SHALL in wrap mode (down), for cnt-s < MIN, set cnt = MAX - (MIN-(cnt-s)-1) mod (MAX-MIN+1) and pulse tc.
REQ-023 SHALL in saturate mode clamp cnt to MAX (up) or MIN (down) on overshoot, and pulse tc only on the edge at which cnt first reaches the bound.
REQ-024 SHALL in saturate mode, while cnt is already at the bound and the count continues toward it, hold cnt and keep tc=0.
REQ-025 SHALL, on a direction reversal at a bound in saturate mode, leave the bound on the next enabled edge after dir updates.
REQ-026 SHALL apply a mode change on the next rising edge with no extra latency.
REQ-027 SHALL clamp a cnt value outside [MIN,MAX] into range before the step is applied. Such a value is unreachable in normal operation.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously force cnt=MIN, dir=0, tc=0, regardless of clk.
REQ-029 SHALL resume counting from MIN on the first rising edge after rst_n deasserts, with dir taken from the u_d sampled at that edge.
REQ-030 SHALL, if reset is asserted mid-sequence or coincident with load, let reset win with no residual tc pulse.

Structure
REQ-031 SHALL place the mode encodings (CNT_WRAP=0, CNT_SAT=1) and the UP/DN direction constants in shared package cnt_pkg.
REQ-032 SHALL isolate the next-value/tc computation in one combinational sub-module cnt_next_calc. All registers SHALL stay in cnt_updown_n.
REQ-033 SHALL include elaboration-time checks that MIN < MAX and that MAX fits in WIDTH.

Verification
Bench parameters: WIDTH=4, MIN=2, MAX=12, STEP_W=2.
REQ-034 SHALL cover reset: assert rst_n=0 mid-count at cnt=7 -> cnt=2, dir=0, tc=0 immediately, without a clk edge.
REQ-035 SHALL cover wrap, up: mode=0, u_d=0, step=3, start 11 -> next values 3 (tc=1), then 6 (tc=0).
REQ-036 SHALL cover wrap, down: mode=0, u_d=1, step=1, start 2 -> next value 12 with tc=1.
REQ-037 SHALL cover saturate: mode=1, u_d=0, step=2, start 10 -> 12 (tc=1), 12 (tc=0), 12 (tc=0). Then set u_d=1 -> one more 12, then 10.
REQ-038 SHALL cover load priority: load=1, load_val=15, en=1 -> cnt=12, tc=0. Then load_val=0 -> cnt=2.
REQ-039 SHALL cover the step=0 and en=0 corner: en=1, step=0, up from 5 -> 6. Then en=0 -> cnt holds at 6, tc=0.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared encodings and helpers for the bounded up/down counter.
package cnt_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam logic UP = 1'b0;
  localparam logic DN = 1'b1;

  function automatic logic [31:0] cnt_clamp(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    logic [31:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_next_calc.sv
// Combinational next-count and terminal-count computation; holds no state.
module cnt_next_calc
  import cnt_pkg::*;
#(
  parameter int    WIDTH  = 4,
  parameter longint MIN   = 0,
  parameter longint MAX   = (64'sd1 <<< WIDTH) - 64'sd1,
  parameter int    STEP_W = 2
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic              dir,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  next_cnt,
  output logic              next_tc,
  output logic [WIDTH-1:0]  load_cnt
);

  // Wide enough that cnt + step and MIN + step never overflow.
  localparam int AW = WIDTH + STEP_W + 1;
  localparam logic [AW-1:0] MIN_A   = AW'(MIN);
  localparam logic [AW-1:0] MAX_A   = AW'(MAX);
  localparam logic [AW-1:0] RANGE_A = AW'(MAX - MIN + 64'sd1);
  localparam logic [AW-1:0] ONE_A   = AW'(1'b1);

  logic [AW-1:0] c_s;
  logic [AW-1:0] s_s;
  logic [AW-1:0] sum_s;
  logic [AW-1:0] nxt_s;
  logic          tc_s;
  logic          sat_s;

  // Step arithmetic with wrap/saturate handling at both bounds.
  always_comb begin
    c_s   = AW'(cnt_clamp(32'(cnt), 32'(MIN), 32'(MAX)));
    s_s   = (step == {STEP_W{1'b0}}) ? ONE_A : AW'(step);
    sum_s = c_s + s_s;
    sat_s = (cnt_mode_e'(mode) == CNT_SAT);
    nxt_s = c_s;
    tc_s  = 1'b0;
    if (dir == UP) begin
      if (sum_s > MAX_A) begin
        if (sat_s) begin
          nxt_s = MAX_A;
          tc_s  = (c_s != MAX_A);
        end else begin
          nxt_s = MIN_A + ((sum_s - MAX_A - ONE_A) % RANGE_A);
          tc_s  = 1'b1;
        end
      end else begin
        nxt_s = sum_s;
        tc_s  = sat_s && (sum_s == MAX_A);
      end
    end else begin
      // c - s < MIN, tested without letting the subtraction go negative
      if (c_s < MIN_A + s_s) begin
        if (sat_s) begin
          nxt_s = MIN_A;
          tc_s  = (c_s != MIN_A);
        end else begin
          nxt_s = MAX_A - ((MIN_A + s_s - c_s - ONE_A) % RANGE_A);
          tc_s  = 1'b1;
        end
      end else begin
        nxt_s = c_s - s_s;
        tc_s  = sat_s && ((c_s - s_s) == MIN_A);
      end
    end
  end

  assign next_cnt = WIDTH'(nxt_s);
  assign next_tc  = tc_s;
  assign load_cnt = WIDTH'(cnt_clamp(32'(load_val), 32'(MIN), 32'(MAX)));

endmodule

// File: rtl/cnt_updown_n.sv
// Bounded up/down counter with variable step, wrap/saturate modes and load.
module cnt_updown_n
  import cnt_pkg::*;
#(
  parameter int    WIDTH  = 4,
  parameter longint MIN   = 0,
  parameter longint MAX   = (64'sd1 <<< WIDTH) - 64'sd1,
  parameter int    STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              u_d,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  cnt,
  output logic              dir,
  output logic              tc
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("cnt_updown_n: WIDTH must be in 2..32");
  end
  if (!(MIN < MAX)) begin : g_bad_bounds
    $error("cnt_updown_n: MIN must be less than MAX");
  end
  if (MIN < 64'sd0 || MAX > ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_bad_fit
    $error("cnt_updown_n: MIN/MAX must fit in WIDTH bits");
  end

  logic [WIDTH-1:0] cnt_r;
  logic             dir_r;
  logic             tc_r;
  logic [WIDTH-1:0] next_cnt_s;
  logic             next_tc_s;
  logic [WIDTH-1:0] load_cnt_s;

  cnt_next_calc #(
    .WIDTH  (WIDTH),
    .MIN    (MIN),
    .MAX    (MAX),
    .STEP_W (STEP_W)
  ) u_calc (
    .cnt      (cnt_r),
    .dir      (dir_r),
    .mode     (mode),
    .step     (step),
    .load_val (load_val),
    .next_cnt (next_cnt_s),
    .next_tc  (next_tc_s),
    .load_cnt (load_cnt_s)
  );

  // State update: load beats enable beats hold; direction always re-sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= WIDTH'(MIN);
      dir_r <= UP;
      tc_r  <= 1'b0;
    end else begin
      dir_r <= u_d;
      if (load) begin
        cnt_r <= load_cnt_s;
        tc_r  <= 1'b0;
      end else if (en) begin
        cnt_r <= next_cnt_s;
        tc_r  <= next_tc_s;
      end else begin
        tc_r  <= 1'b0;
      end
    end
  end

  assign cnt = cnt_r;
  assign dir = dir_r;
  assign tc  = tc_r;

endmodule

// File: tb/tb_cnt_updown_n.sv
// Scoreboard bench for cnt_updown_n (WIDTH=4, MIN=2, MAX=12, STEP_W=2).
module tb_cnt_updown_n;

  localparam int MINV = 2;
  localparam int MAXV = 12;
  localparam int RNG  = MAXV - MINV + 1;

  typedef struct {
    int cnt;
    int dir;
    int tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       u_d = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] step = 2'd0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] cnt;
  logic       dir;
  logic       tc;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   m_cnt = MINV;
  int   m_dir = 0;
  int   m_tc  = 0;

  cnt_updown_n #(.WIDTH(4), .MIN(2), .MAX(12), .STEP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .u_d(u_d), .mode(mode), .step(step),
    .load(load), .load_val(load_val), .cnt(cnt), .dir(dir), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input int expv);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v < MINV) ? MINV : ((v > MAXV) ? MAXV : v);
  endfunction

  // Reference: counter as an integer on the closed range [MINV, MAXV].
  task automatic model_edge();
    int c, s, t;
    c = clampv(m_cnt);
    s = (step == 2'd0) ? 1 : int'(step);
    if (load) begin
      m_cnt = clampv(int'(load_val));
      m_tc  = 0;
    end else if (en) begin
      t = (m_dir == 0) ? c + s : c - s;
      if (t > MAXV) begin
        m_cnt = mode ? MAXV : MINV + (t - MAXV - 1) % RNG;
        m_tc  = mode ? (c != MAXV) : 1;
      end else if (t < MINV) begin
        m_cnt = mode ? MINV : MAXV - (MINV - t - 1) % RNG;
        m_tc  = mode ? (c != MINV) : 1;
      end else begin
        m_cnt = t;
        m_tc  = (mode && (t == MAXV || t == MINV)) ? 1 : 0;
      end
    end else begin
      m_tc = 0;
    end
    m_dir = int'(u_d);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.cnt = m_cnt; e.dir = m_dir; e.tc = m_tc;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic drive(input logic ld, input int lv, input logic e, input logic ud,
                       input logic md, input int st);
    load = ld; load_val = 4'(lv); en = e; u_d = ud; mode = md; step = 2'(st);
    cycle();
  endtask

  // Async reset between edges; outputs must clear with no clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(cnt), MINV);
    check("async_rst_dir", 32'(dir), 0);
    check("async_rst_tc",  32'(tc),  0);
    #1;
    rst_n = 1'b1;
    m_cnt = MINV; m_dir = 0; m_tc = 0;
  endtask

  // Monitor: each cycle's registered outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cnt", 32'(cnt), e.cnt);
      check("dir", 32'(dir), e.dir);
      check("tc",  32'(tc),  e.tc);
    end
  end

  initial begin
    logic ud_r, md_r;
    #12;
    check("rst_cnt", 32'(cnt), MINV);
    check("rst_dir", 32'(dir), 0);
    check("rst_tc",  32'(tc),  0);
    rst_n = 1'b1;

    // first edge after reset counts up from MIN
    drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 1);
    // wrap up: 11 +3 -> 3 (tc), 6
    drive(1'b1, 11, 1'b0, 1'b0, 1'b0, 3);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 3);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 3);
    // wrap down: 2 -1 -> 12 (tc)
    drive(1'b1, 2, 1'b0, 1'b1, 1'b0, 1);
    drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 1);
    // saturate up from 10, then reverse at the bound
    drive(1'b1, 10, 1'b0, 1'b0, 1'b1, 2);
    repeat (3) drive(1'b0, 0, 1'b1, 1'b0, 1'b1, 2);
    repeat (2) drive(1'b0, 0, 1'b1, 1'b1, 1'b1, 2);
    // load priority with clamping on both sides
    drive(1'b1, 15, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b1, 0, 1'b1, 1'b0, 1'b0, 1);
    // step=0 acts as 1, then hold
    drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    // reset mid-count at 7
    drive(1'b1, 6, 1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1);
    do_reset();
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1);

    ud_r = 1'b0;
    md_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) ud_r = ~ud_r;
      if ($urandom_range(0, 7) == 0) md_r = ~md_r;
      if ($urandom_range(0, 99) == 0) do_reset();
      drive(($urandom_range(0, 11) == 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 4) != 0), ud_r, md_r, int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
